// File: rtl/regfile_sb.sv
// Register file with per-register pending-write scoreboard: 2 comb read ports, 1 sync write port, WAW issue stall.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic [ADDR_W-1:0] iAddrA,
  input  logic [ADDR_W-1:0] iAddrB,
  output logic [DATA_W-1:0] oRegA,
  output logic [DATA_W-1:0] oRegB,
  output logic              oBusyA,
  output logic              oBusyB,
  input  logic              iWrite,
  input  logic [ADDR_W-1:0] iAddrC,
  input  logic [DATA_W-1:0] iRegC,
  input  logic              iIssue,
  input  logic [ADDR_W-1:0] iIssueAddr,
  output logic              oIssueStall,
  input  logic              iFlush
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic wr_en;
  logic stall;
  logic issue_acc;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr_en = iWrite & ~is_zero(iAddrC);

  // A writeback landing on the same edge releases the old owner, so it does not stall.
  assign stall = iIssue & busy_q[iIssueAddr] & ~(iWrite & (iAddrC == iIssueAddr))
               & ~iFlush & ~is_zero(iIssueAddr);

  assign issue_acc   = iIssue & ~iFlush & ~stall & ~is_zero(iIssueAddr);
  assign oIssueStall = stall;

  // Priority: flush > issue set > write clear.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[iAddrC] = 1'b0;
    end
    if (issue_acc) begin
      busy_d[iIssueAddr] = 1'b1;
    end
    if (iFlush) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[iAddrC] <= iRegC;
    end
  end

  always_comb begin
    oRegA  = is_zero(iAddrA) ? '0 : regs_q[iAddrA];
    oBusyA = is_zero(iAddrA) ? 1'b0 : busy_q[iAddrA];
`ifdef REGFILE_BYPASS_EN
    if (nRst && wr_en && (iAddrA == iAddrC)) begin
      oRegA  = iRegC;
      oBusyA = issue_acc && (iIssueAddr == iAddrA);
    end
`endif
  end

  always_comb begin
    oRegB  = is_zero(iAddrB) ? '0 : regs_q[iAddrB];
    oBusyB = is_zero(iAddrB) ? 1'b0 : busy_q[iAddrB];
`ifdef REGFILE_BYPASS_EN
    if (nRst && wr_en && (iAddrB == iAddrC)) begin
      oRegB  = iRegC;
      oBusyB = issue_acc && (iIssueAddr == iAddrB);
    end
`endif
  end

endmodule
